core8_cpu_6_oci_dct_packer: RTL and testbench
=============================================

Name: core8_cpu_6_oci_dct_packer

Overview:
- Upstream feeder for the OCI trace test-bench monitor.
- Packs 2-bit compressed trace symbols from the OCI trace path into a 30-bit buffer of 15 slots.
- Exposes the live buffer and count as dct_buffer / dct_count, and emits full or flushed packets through a valid/ready holding register.
- Sequences end of test and drives test_ending / test_has_ended for the monitor.

Parameters:
- SYM_W, 2: bits per trace symbol.
- SLOTS, 15: symbol slots per packet. Buffer width is SYM_W*SLOTS = 30.
- CNT_W, 4: width of the slot count. Must satisfy 2^CNT_W > SLOTS.
- STALL_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sym_valid  in  1  a trace symbol is offered.
- sym  in  2  trace symbol.
- sym_ready  out  1  packer accepts sym this cycle.
- end_req  in  1  one-cycle request to end the test and flush.
- dct_buffer  out  30  live accumulator; newest symbol is in bits [1:0].
- dct_count  out  4  number of valid symbols in dct_buffer, 0..15.
- pkt_valid  out  1  holding register holds a packet.
- pkt_data  out  30  packet payload, right-aligned.
- pkt_count  out  4  symbols in the packet, 1..15.
- pkt_ready  in  1  consumer takes the packet.
- test_ending  out  1  flush in progress.
- test_has_ended  out  1  flush complete; sticky.
- stall_cnt  out  16  saturating count of cycles with sym_valid=1 and sym_ready=0.

Behaviour:
- Reset, asynchronous: every output and register goes to 0 and the FSM goes to RUN. This includes sym_ready, which returns to 1 on the first edge after reset release. Reset mid-packet discards the buffer and holding register without emitting anything.
- Accept: accept = sym_valid & sym_ready. On accept, acc <= {acc[27:0], sym} and count <= count+1.
- Holding free: hold_free = !pkt_valid | pkt_ready.
- Transfer condition: xfer = hold_free & ((count==SLOTS) | (state==DRAIN & count!=0)).
- On xfer:
  - pkt_data <= acc, pkt_count <= count, pkt_valid <= 1.
  - acc and count clear to 0.
  - If accept happens in the same cycle, acc <= {28'b0, sym} and count <= 1. Symbols are never lost or reordered.
- Pop without transfer: pkt_valid & pkt_ready & !xfer sets pkt_valid <= 0.
- sym_ready = (state==RUN) & ((count<SLOTS) | xfer).
- Latency: the symbol that fills slot 15 is accepted at edge N. The transfer happens at edge N+1 if the holding register is free, so pkt_valid is high after N+1. While full and blocked, sym_ready=0 and the buffer is held.
- pkt_data and pkt_count are stable while pkt_valid=1 and pkt_ready=0.
- Partial packets (flush only) are right-aligned: valid symbols occupy bits [2*pkt_count-1:0] and upper bits are 0.
- FSM:
  - RUN: on end_req, go to DRAIN. end_req in any other state is ignored.
  - DRAIN: sym_ready=0 and test_ending=1. If count==0, or xfer occurs this cycle, go to WAIT.
  - WAIT: test_ending=1. When pkt_valid=0, or pkt_valid & pkt_ready, go to ENDED.
  - ENDED: test_ending=0 and test_has_ended=1 until reset. sym_ready=0.
- end_req with accept in the same cycle: the symbol is accepted (RUN still holds that cycle) and is then included in the flush.
- stall_cnt increments on each cycle with sym_valid & !sym_ready and saturates at 0xFFFF.
- All outputs are registered except sym_ready, which is combinational from state, count, pkt_valid and pkt_ready.

Test Plan:
- Fill: 15 accepts of sym=2'b01 with pkt_ready=1.
  - Expect dct_count to step 1..15.
  - Expect pkt_valid high one cycle after the 15th accept, with pkt_data=30'h15555555 and pkt_count=15.
  - Expect dct_count=0 after the transfer.
- Backpressure: pkt_ready=0 and 30 symbols offered.
  - First packet is held stable; second buffer fills to 15; sym_ready drops; stall_cnt counts the blocked cycles.
  - Raising pkt_ready pops packet 1, transfers packet 2 next cycle, and sym_ready returns.
- Flush partial: 3 symbols 11,10,01, then end_req.
  - Expect test_ending=1 and a packet with pkt_data=30'h39 and pkt_count=3.
  - After the pop, test_has_ended=1, test_ending=0, sym_ready=0.
- Flush empty: end_req with count=0 and no packet held.
  - Expect DRAIN, then WAIT, then ENDED over 2 cycles, with no pkt_valid pulse.
- Simultaneous events: count=15, holding free, accept in the same cycle.
  - Expect the packet out with 15 symbols and dct_count=1 holding the new symbol.
  - Also: end_req together with an accept; the symbol appears in the flushed packet.
- Reset mid-operation: assert reset while count=7 and pkt_valid=1.
  - Expect all outputs 0 immediately, without waiting for a clock edge.
  - After release, normal packing resumes from an empty buffer.

Source files
------------

// File: rtl/core8_cpu_6_oci_dct_packer.sv
// OCI trace DCT packer: packs 2-bit trace symbols into 15-slot packets behind a
// valid/ready holding register and sequences the end-of-test flush for the monitor.

module core8_cpu_6_oci_dct_packer #(
  parameter int SYM_W   = 2,
  parameter int SLOTS   = 15,
  parameter int CNT_W   = 4,
  parameter int STALL_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sym_valid,
  input  logic [SYM_W-1:0]       sym,
  output logic                   sym_ready,
  input  logic                   end_req,
  output logic [SYM_W*SLOTS-1:0] dct_buffer,
  output logic [CNT_W-1:0]       dct_count,
  output logic                   pkt_valid,
  output logic [SYM_W*SLOTS-1:0] pkt_data,
  output logic [CNT_W-1:0]       pkt_count,
  input  logic                   pkt_ready,
  output logic                   test_ending,
  output logic                   test_has_ended,
  output logic [STALL_W-1:0]     stall_cnt
);

  localparam int BUF_W = SYM_W * SLOTS;
  localparam logic [CNT_W-1:0]   SLOTS_C   = CNT_W'(SLOTS);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_WAIT,
    ST_ENDED
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic [BUF_W-1:0]   pkt_data_q, pkt_data_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic               test_ending_q, test_ending_d;
  logic               test_has_ended_q, test_has_ended_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               ready_en_q;

  logic hold_free;
  logic full;
  logic xfer;
  logic accept;

  // ready_en_q keeps sym_ready low while reset is held and for the cycle after release
  always_comb begin
    full      = (count_q == SLOTS_C);
    hold_free = !pkt_valid_q || pkt_ready;
    xfer      = hold_free && (full || ((state_q == ST_DRAIN) && (count_q != '0)));
    sym_ready = ready_en_q && (state_q == ST_RUN) && ((count_q < SLOTS_C) || xfer);
    accept    = sym_valid && sym_ready;
  end

  // An accept coincident with a transfer starts the fresh buffer with that symbol
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (xfer) begin
      if (accept) begin
        acc_d   = {{(BUF_W-SYM_W){1'b0}}, sym};
        count_d = CNT_ONE;
      end else begin
        acc_d   = '0;
        count_d = '0;
      end
    end else if (accept) begin
      acc_d   = {acc_q[BUF_W-SYM_W-1:0], sym};
      count_d = count_q + CNT_ONE;
    end
  end

  always_comb begin
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    pkt_count_d = pkt_count_q;
    if (xfer) begin
      pkt_valid_d = 1'b1;
      pkt_data_d  = acc_q;
      pkt_count_d = count_q;
    end else if (pkt_valid_q && pkt_ready) begin
      pkt_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (end_req) state_d = ST_DRAIN;
      ST_DRAIN: if ((count_q == '0) || xfer) state_d = ST_WAIT;
      ST_WAIT:  if (!pkt_valid_q || pkt_ready) state_d = ST_ENDED;
      default:  state_d = ST_ENDED;
    endcase
    test_ending_d    = (state_d == ST_DRAIN) || (state_d == ST_WAIT);
    test_has_ended_d = (state_d == ST_ENDED);
  end

  always_comb begin
    stall_d = stall_q;
    if (sym_valid && !sym_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_RUN;
      acc_q            <= '0;
      count_q          <= '0;
      pkt_valid_q      <= 1'b0;
      pkt_data_q       <= '0;
      pkt_count_q      <= '0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
      stall_q          <= '0;
      ready_en_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      acc_q            <= acc_d;
      count_q          <= count_d;
      pkt_valid_q      <= pkt_valid_d;
      pkt_data_q       <= pkt_data_d;
      pkt_count_q      <= pkt_count_d;
      test_ending_q    <= test_ending_d;
      test_has_ended_q <= test_has_ended_d;
      stall_q          <= stall_d;
      ready_en_q       <= 1'b1;
    end
  end

  assign dct_buffer     = acc_q;
  assign dct_count      = count_q;
  assign pkt_valid      = pkt_valid_q;
  assign pkt_data       = pkt_data_q;
  assign pkt_count      = pkt_count_q;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_core8_cpu_6_oci_dct_packer.sv
// Bench for the OCI DCT packer: a symbol-level model builds expected packets into
// a scoreboard queue, popped and compared at every packet handshake.

module tb_core8_cpu_6_oci_dct_packer;

  typedef struct packed {
    logic [29:0] data;
    logic [3:0]  cnt;
  } pkt_t;

  logic        clk;
  logic        reset;
  logic        sym_valid;
  logic [1:0]  sym;
  logic        sym_ready;
  logic        end_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        pkt_valid;
  logic [29:0] pkt_data;
  logic [3:0]  pkt_count;
  logic        pkt_ready;
  logic        test_ending;
  logic        test_has_ended;
  logic [15:0] stall_cnt;

  int          tests_run;
  int          tests_failed;
  pkt_t        exp_q[$];
  logic [29:0] mdl_data;
  int          mdl_cnt;
  logic        mdl_ending;
  int          accepts;

  core8_cpu_6_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .sym_valid      (sym_valid),
    .sym            (sym),
    .sym_ready      (sym_ready),
    .end_req        (end_req),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .pkt_valid      (pkt_valid),
    .pkt_data       (pkt_data),
    .pkt_count      (pkt_count),
    .pkt_ready      (pkt_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pushPkt();
    pkt_t p;
    p.data = mdl_data;
    p.cnt  = 4'(mdl_cnt);
    exp_q.push_back(p);
    mdl_data = '0;
    mdl_cnt  = 0;
  endtask

  task automatic clearModel();
    exp_q.delete();
    mdl_data   = '0;
    mdl_cnt    = 0;
    mdl_ending = 1'b0;
  endtask

  // Drives one cycle, then updates the symbol model and scores any packet handshake
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic pr, input logic er);
    logic        acc_obs;
    logic        hs;
    logic [29:0] obs_data;
    logic [3:0]  obs_cnt;
    pkt_t        e;
    @(negedge clk);
    sym_valid = v;
    sym       = s;
    pkt_ready = pr;
    end_req   = er;
    #1;
    acc_obs  = v & sym_ready;
    hs       = pkt_valid & pr;
    obs_data = pkt_data;
    obs_cnt  = pkt_count;
    @(posedge clk);
    #1;
    if (acc_obs) begin
      accepts++;
      mdl_data = {mdl_data[27:0], s};
      mdl_cnt++;
      if (mdl_cnt == 15) pushPkt();
    end
    if (er && !mdl_ending) begin
      mdl_ending = 1'b1;
      if (mdl_cnt > 0) pushPkt();
    end
    if (hs) begin
      checkOutput("sb_pkt_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_pkt_data", 64'(obs_data), 64'(e.data));
        checkOutput("sb_pkt_count", 64'(obs_cnt), 64'(e.cnt));
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset     = 1'b1;
    sym_valid = 1'b0;
    end_req   = 1'b0;
    clearModel();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bp_start;
    tests_run    = 0;
    tests_failed = 0;
    accepts      = 0;
    clearModel();
    reset     = 1'b0;
    sym_valid = 1'b0;
    sym       = 2'b00;
    end_req   = 1'b0;
    pkt_ready = 1'b1;

    #1 reset = 1'b1;
    #1;
    checkOutput("rst_ctrl", {dct_count, pkt_valid, pkt_count, test_ending, test_has_ended, stall_cnt, sym_ready}, 64'd0);
    checkOutput("rst_buffers", {dct_buffer, pkt_data}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_ready_before_edge", 64'(sym_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_ready_after_edge", 64'(sym_ready), 64'd1);

    // fill one packet with 01 symbols and an always-ready consumer
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
      checkOutput("fill_count", 64'(dct_count), 64'(i));
    end
    checkOutput("fill_no_pkt_yet", 64'(pkt_valid), 64'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("fill_pkt_valid", 64'(pkt_valid), 64'd1);
    checkOutput("fill_pkt_data", 64'(pkt_data), 64'h15555555);
    checkOutput("fill_pkt_count", 64'(pkt_count), 64'd15);
    checkOutput("fill_count_cleared", 64'(dct_count), 64'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("fill_popped", 64'(pkt_valid), 64'd0);

    // backpressure: 30 symbols with a stalled consumer, then 5 blocked offers
    bp_start = accepts;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 2'(i % 4), 1'b0, 1'b0);
      if (i == 15) begin
        checkOutput("simul_pkt_valid", 64'(pkt_valid), 64'd1);
        checkOutput("simul_pkt_count", 64'(pkt_count), 64'd15);
        checkOutput("simul_dct_count", 64'(dct_count), 64'd1);
        checkOutput("simul_dct_buffer", 64'(dct_buffer), 64'd3);
      end
    end
    checkOutput("bp_accepts", 64'(accepts - bp_start), 64'd30);
    checkOutput("bp_full_count", 64'(dct_count), 64'd15);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("bp_ready_low", 64'(sym_ready), 64'd0);
    checkOutput("bp_stall_cnt", 64'(stall_cnt), 64'd5);
    checkOutput("bp_hold_data", 64'(pkt_data), 64'(exp_q[0].data));
    checkOutput("bp_hold_count", 64'(pkt_count), 64'd15);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("bp_pkt2_valid", 64'(pkt_valid), 64'd1);
    checkOutput("bp_pkt2_data", 64'(pkt_data), 64'(exp_q[0].data));
    checkOutput("bp_buffer_empty", 64'(dct_count), 64'd0);
    checkOutput("bp_ready_back", 64'(sym_ready), 64'd1);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // reset mid-operation with count=7 and a held packet
    for (int i = 0; i < 22; i++) applyStimulus(1'b1, 2'(i % 4), 1'b0, 1'b0);
    checkOutput("mid_count7", 64'(dct_count), 64'd7);
    checkOutput("mid_pkt_held", 64'(pkt_valid), 64'd1);
    @(negedge clk);
    sym_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_ctrl", {dct_count, pkt_valid, pkt_count, test_ending, test_has_ended, stall_cnt, sym_ready}, 64'd0);
    checkOutput("mid_rst_buffers", {dct_buffer, pkt_data}, 64'd0);
    clearModel();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // partial flush of 11,10,01
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
    checkOutput("part_buffer", 64'(dct_buffer), 64'h39);
    checkOutput("part_count", 64'(dct_count), 64'd3);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
    checkOutput("part_drain_ending", 64'(test_ending), 64'd1);
    checkOutput("part_drain_ready", 64'(sym_ready), 64'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("part_pkt_valid", 64'(pkt_valid), 64'd1);
    checkOutput("part_pkt_data", 64'(pkt_data), 64'h39);
    checkOutput("part_pkt_count", 64'(pkt_count), 64'd3);
    checkOutput("part_wait_ending", 64'(test_ending), 64'd1);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("part_ended", {test_has_ended, test_ending, sym_ready, pkt_valid}, 64'b1000);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b1);
    checkOutput("part_ended_stall", 64'(stall_cnt), 64'd1);
    checkOutput("part_ended_sticky", {test_has_ended, test_ending, dct_count}, 64'b10_0000);

    // empty flush: DRAIN, WAIT, ENDED with no packet
    doReset();
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
    checkOutput("empty_drain", {test_ending, test_has_ended, pkt_valid}, 64'b100);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("empty_wait", {test_ending, test_has_ended, pkt_valid}, 64'b100);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("empty_ended", {test_ending, test_has_ended, pkt_valid}, 64'b010);

    // end_req together with an accept: that symbol joins the flush
    doReset();
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b1);
    checkOutput("endacc_count", 64'(dct_count), 64'd3);
    checkOutput("endacc_model", 64'(exp_q.size() > 0 ? exp_q[0].data : 30'h0), 64'h1A);
    for (int i = 0; i < 10; i++) begin
      if (!test_has_ended) applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    end
    checkOutput("endacc_ended", 64'(test_has_ended), 64'd1);
    checkOutput("endacc_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
